// File: rtl/siggen_probe.sv
// Probe-clock / gate / serial-data generator for a signature analyzer.
// Params DIV, WINDOW, GAP. Inputs clock, reset_l, go, sel[3:0], loop.
// Outputs probe_clock, probe_start, probe_stop, probe_data, busy, done.
// Define SIGGEN_REPEAT_EN to let loop restart a window after the gap.
module siggen_probe #(
  parameter int DIV    = 4,
  parameter int WINDOW = 1024,
  parameter int GAP    = 16
) (
  input  logic       clock,
  input  logic       reset_l,
  input  logic       go,
  input  logic [3:0] sel,
  input  logic       loop,
  output logic       probe_clock,
  output logic       probe_start,
  output logic       probe_stop,
  output logic       probe_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  localparam logic [8:0]  PH_HI  = 9'(DIV - 1);
  localparam logic [8:0]  PH_END = 9'(2 * DIV - 1);
  localparam logic [15:0] E_LAST = 16'(WINDOW);
  localparam logic [7:0]  G_LAST = 8'(GAP - 1);

  state_t      state;
  logic [8:0]  ph;
  logic [15:0] e;
  logic [7:0]  g;
  logic [3:0]  sel_q;
  logic [15:0] e_nx;
  logic        rep;

  assign e_nx = e + 16'd1;

`ifdef SIGGEN_REPEAT_EN
  assign rep = loop;
`else
  assign rep = loop & 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state       <= S_IDLE;
      ph          <= '0;
      e           <= '0;
      g           <= '0;
      sel_q       <= '0;
      probe_clock <= 1'b0;
      probe_start <= 1'b0;
      probe_stop  <= 1'b0;
      probe_data  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            // Period 0 starts now; bit sel of counter value 0 is 0.
            state       <= S_RUN;
            sel_q       <= sel;
            e           <= '0;
            ph          <= '0;
            probe_clock <= 1'b0;
            probe_start <= 1'b1;
            probe_stop  <= 1'b0;
            probe_data  <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_RUN, S_GAP: begin
          if (ph == PH_HI) probe_clock <= 1'b1;
          if (ph != PH_END) begin
            ph <= ph + 9'd1;
          end else begin
            // Falling transition: the only point gates/data move.
            ph          <= '0;
            probe_clock <= 1'b0;
            if (state == S_RUN) begin
              if (e != E_LAST) begin
                e           <= e_nx;
                probe_data  <= e_nx[sel_q];
                probe_start <= 1'b0;
                probe_stop  <= (e_nx == E_LAST);
              end else begin
                state       <= S_GAP;
                g           <= '0;
                probe_start <= 1'b0;
                probe_stop  <= 1'b0;
                probe_data  <= 1'b0;
              end
            end else if (g != G_LAST) begin
              g <= g + 8'd1;
            end else begin
              done <= 1'b1;
              if (rep) begin
                state       <= S_RUN;
                sel_q       <= sel;
                e           <= '0;
                probe_start <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/siggen_probe.md
SIGGEN_PROBE -- requirements
Module: siggen_probe

Interface
REQ-001 SHALL have parameter DIV, default 4: probe-clock half-period in system clocks (legal 2..255).
REQ-002 SHALL have parameter WINDOW, default 1024: probe-clock rising edges from start edge to stop edge (legal 2..65535).
REQ-003 SHALL have parameter GAP, default 16: idle probe-clock periods after the stop edge before done (legal 1..255).
REQ-004 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_l  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port go  input  1  level; starts one measurement window when sampled high in IDLE.
REQ-007 SHALL have port sel  input  4  selects the pattern-counter bit driven on probe_data; sampled on leaving IDLE.
REQ-008 SHALL have port loop  input  1  repeat request (see Configuration).
REQ-009 SHALL have port probe_clock  output  1  generated probe clock for the signature analyzer.
REQ-010 SHALL have port probe_start  output  1  start gate, active-high.
REQ-011 SHALL have port probe_stop  output  1  stop gate, active-high.
REQ-012 SHALL have port probe_data  output  1  serial test data.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-system-clock pulse on completion of a window plus gap.

Function
REQ-015 SHALL implement states IDLE, RUN and GAP; all outputs registered.
REQ-016 A probe period SHALL be 2*DIV system clocks: probe_clock low for DIV clocks, then high for DIV clocks; the rising edge is the low-to-high transition.
REQ-017 IDLE: probe_clock low; probe_start, probe_stop, probe_data low; go=1 latches sel, clears edge counter e, enters RUN on the next clock.
REQ-018 RUN: probe periods numbered e=0..WINDOW; probe_data SHALL equal bit sel of 16-bit pattern counter value e, updated at the start of the low half of period e.
REQ-019 probe_start SHALL be high for the whole of period 0 and low otherwise; probe_stop SHALL be high for the whole of period WINDOW and low otherwise.
REQ-020 Setup and hold SHALL each be DIV system clocks: gates and data change only at the falling transition (period start).
REQ-021 After period WINDOW, SHALL enter GAP: probe_clock keeps toggling for GAP periods with gates and data low.
REQ-022 At the end of GAP, SHALL pulse done for exactly one clock and return to IDLE, or restart RUN per REQ-027.
REQ-023 go SHALL be ignored outside IDLE; sel changes outside IDLE SHALL have no effect.
REQ-024 sel values 10..15 SHALL select counter bits 10..15; the counter is 16 bits and wraps modulo 65536.

Reset
REQ-025 reset_l low SHALL asynchronously force IDLE, clear all counters, and drive probe_clock, probe_start, probe_stop, probe_data, busy and done low.
REQ-026 Reset asserted mid-window SHALL abort with no done pulse; after release the block waits in IDLE for go.

Configuration
REQ-027 With SIGGEN_REPEAT_EN defined, loop=1 sampled at the end of GAP SHALL restart RUN at e=0 with sel re-latched, still pulsing done; without it, loop SHALL be ignored and the block SHALL always return to IDLE.

Verification
REQ-028 DIV=4, WINDOW=8, GAP=2, sel=0, go pulse -> 9 probe rising edges with data 0,1,0,1,0,1,0,1,0; start high only at edge 0; stop high only at edge 8.
REQ-029 Same parameters -> done pulses exactly once, 2*4*(9+2) system clocks after RUN entry; busy low on the next clock.
REQ-030 Default parameters, sel=9, go -> window output fed to sigan (driven through inversion) yields a signature stable across two runs and equal to the golden model value.
REQ-031 reset_l pulled low at edge 5 of a WINDOW=8 run -> all outputs low within the same clock, no done pulse, next go produces a complete window.
REQ-032 SIGGEN_REPEAT_EN defined, loop=1 -> back-to-back windows separated by exactly GAP periods, done once per window; loop dropped -> IDLE after the current gap.
REQ-033 go held high continuously in the default build -> successive windows, each starting one system clock after the previous done.
